// File: rtl/uart_link_arbiter.sv
// Round-robin arbiter that lets two UART requesters share one half-duplex serial line.
// Frames each accepted byte as start + DATA_W bits LSB-first + stop, then holds a turnaround gap.
module uart_link_arbiter #(
    parameter int BIT_CYCLES = 2,
    parameter int TURN_GAP   = 2,
    parameter int DATA_W     = 8
) (
    input  logic              clk_sis,
    input  logic              rst,
    input  logic              valid_0,
    input  logic [DATA_W-1:0] data_0,
    output logic              ready_0,
    output logic              done_0,
    input  logic              valid_1,
    input  logic [DATA_W-1:0] data_1,
    output logic              ready_1,
    output logic              done_1,
    output logic              tx,
    output logic              busy,
    output logic              owner
);

    localparam int BT_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int GT_W  = (TURN_GAP > 1) ? $clog2(TURN_GAP) : 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BT_W-1:0]  BIT_LAST = BT_W'(BIT_CYCLES - 1);
    localparam logic [GT_W-1:0]  GAP_LAST = GT_W'(TURN_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BT_W-1:0]   bit_tmr_q, bit_tmr_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GT_W-1:0]   gap_tmr_q, gap_tmr_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              done_0_q, done_0_d;
    logic              done_1_q, done_1_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;

    // Ties go to whichever port did not win last; last_grant resets to 1 so port 0 wins first.
    assign ready_0 = (state_q == S_IDLE) & valid_0 & (~valid_1 | last_grant_q);
    assign ready_1 = (state_q == S_IDLE) & valid_1 & (~valid_0 | ~last_grant_q);

    assign done_0 = done_0_q;
    assign done_1 = done_1_q;
    assign tx     = tx_q;
    assign busy   = busy_q;
    assign owner  = owner_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_tmr_d    = bit_tmr_q;
        bit_cnt_d    = bit_cnt_q;
        gap_tmr_d    = gap_tmr_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        done_0_d     = 1'b0;
        done_1_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ready_0) begin
                    shift_d      = data_0;
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    bit_tmr_d    = '0;
                    state_d      = S_START;
                end else if (ready_1) begin
                    shift_d      = data_1;
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    bit_tmr_d    = '0;
                    state_d      = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_tmr_q == BIT_LAST) begin
                    bit_tmr_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    bit_tmr_d = bit_tmr_q + BT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_tmr_q == BIT_LAST) begin
                    bit_tmr_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_cnt_q == CNT_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    bit_tmr_d = bit_tmr_q + BT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_tmr_q == BIT_LAST) begin
                    bit_tmr_d = '0;
                    if (owner_q) begin
                        done_1_d = 1'b1;
                    end else begin
                        done_0_d = 1'b1;
                    end
                    if (TURN_GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_tmr_d = '0;
                        state_d   = S_GAP;
                    end
                end else begin
                    bit_tmr_d = bit_tmr_q + BT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_tmr_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_tmr_d = gap_tmr_q + GT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // tx is registered, so it is derived from where the FSM is heading.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sis) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_tmr_q    <= '0;
            bit_cnt_q    <= '0;
            gap_tmr_q    <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            done_0_q     <= 1'b0;
            done_1_q     <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_tmr_q    <= bit_tmr_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_tmr_q    <= gap_tmr_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            done_0_q     <= done_0_d;
            done_1_q     <= done_1_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

endmodule
